serial_adder_ctrl: RTL and testbench

//  Bit-serial N-bit adder sequencer built around a single 1-bit Full_Adder cell.

---
 rtl/serial_adder_ctrl_pkg.sv | 13 +
 rtl/serial_adder_ctrl_fa.sv | 16 +
 rtl/serial_adder_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encodings
// and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single 1-bit full adder cell; the only arithmetic in the sequencer.
module serial_adder_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Gate-level sum and majority carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, pushes them LSB-first
// through one full adder cell (one bit per clock), then reports sum/cout with
// a one-cycle done pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | waiting for start
//   ST_RUN  | one operand bit per clock, WIDTH cycles
//   ST_DONE | sum/cout valid, done high; start here chains directly
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;

    // The counter is a bitwise ripple increment so the full adder cell stays
    // the block's only adder.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          c;
        r = '0;
        c = 1'b1;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[i] ^ c;
            c    = c & v[i];
        end
        return r;
    endfunction

    serial_adder_ctrl_fa u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Result register shifted right with the new sum bit entering at the MSB;
    // written bitwise so it also holds for WIDTH=1.
    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = fa_s;
    end

    // Sequencer FSM with registered busy/done/sum/cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry <= fa_cout;
                    res   <= res_next;
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt_inc(cnt);
                    if (cnt == LAST_BIT) begin
                        sum   <= res_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances, fixed vectors,
// hand-written corner sequences and random operands against a+b+cin.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n8;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       rst_n1;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int checks;
    int failures;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n8),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // One WIDTH=8 operation, entered #1 after an edge with the DUT in IDLE or
    // DONE. Returns #1 after the edge where done is expected.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                       input logic [7:0] es, input logic ec, input int pulse_at,
                       input string nm);
        int         m;
        int         busy_cnt;
        logic       stable;
        logic [7:0] prev_s;
        logic       prev_c;
        prev_s = sum8;
        prev_c = cout8;
        a8     = ta;
        b8     = tbv;
        cin8   = tc;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8   = 1'b0;
        a8       = 8'($urandom);
        b8       = 8'($urandom);
        cin8     = 1'($urandom_range(1));
        m        = 0;
        busy_cnt = 0;
        stable   = 1'b1;
        while (!done8 && m < 20) begin
            if (busy8) busy_cnt++;
            if (sum8 !== prev_s || cout8 !== prev_c) stable = 1'b0;
            if (m == pulse_at) begin
                start8 = 1'b1;
                a8     = 8'h11;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            m++;
        end
        start8 = 1'b0;
        chk({nm, "_latency"}, 32'(m), 32'd8);
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({nm, "_held_during_run"}, 32'(stable), 32'd1);
        chk({nm, "_sum"}, 32'(sum8), 32'(es));
        chk({nm, "_cout"}, 32'(cout8), 32'(ec));
        chk({nm, "_busy_at_done"}, 32'(busy8), 32'd0);
    endtask

    // DONE without start must fall to IDLE after one cycle.
    task automatic idle8(input string nm);
        @(posedge clk); #1;
        chk({nm, "_done_pulse_len"}, 32'(done8), 32'd0);
        chk({nm, "_idle_busy"}, 32'(busy8), 32'd0);
    endtask

    task automatic count_done8(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done8) n++;
        end
    endtask

    task automatic op1(input logic ta, input logic tbv, input logic tc, input string nm);
        int         m;
        int         busy_cnt;
        logic [1:0] exp;
        exp    = 2'(ta) + 2'(tbv) + 2'(tc);
        a1     = ta;
        b1     = tbv;
        cin1   = tc;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1   = 1'b0;
        m        = 0;
        busy_cnt = 0;
        while (!done1 && m < 10) begin
            if (busy1) busy_cnt++;
            @(posedge clk); #1;
            m++;
        end
        chk({nm, "_latency"}, 32'(m), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd1);
        chk({nm, "_sum"}, 32'(sum1), 32'(exp[0]));
        chk({nm, "_cout"}, 32'(cout1), 32'(exp[1]));
    endtask

    initial begin
        vec_t       vecs[8];
        int         nd;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] model;

        checks   = 0;
        failures = 0;
        rst_n8   = 1'b0;
        rst_n1   = 1'b0;
        start8   = 1'b0;
        start1   = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        #12;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_w1_sum", 32'(sum1), 32'd0);
        @(negedge clk);
        rst_n8 = 1'b1;
        rst_n1 = 1'b1;
        @(posedge clk); #1;

        // Fixed vectors, alternating idle gaps and back-to-back starts.
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, -1,
                $sformatf("vec%0d", i));
            if (i % 2 == 0) idle8($sformatf("vec%0d", i));
        end
        idle8("vec_end");

        // start pulse mid-RUN is ignored
        op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 3, "ignore_start");
        count_done8(12, nd);
        chk("ignore_start_extra_done", 32'(nd), 32'd0);

        // back-to-back from DONE
        op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1, "b2b_first");
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, -1, "b2b_second");
        idle8("b2b");

        // reset on the 4th RUN cycle
        op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1, "pre_reset");
        idle8("pre_reset");
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst_n8 = 1'b0;
        #1;
        chk("midrun_rst_busy", 32'(busy8), 32'd0);
        chk("midrun_rst_done", 32'(done8), 32'd0);
        chk("midrun_rst_sum", 32'(sum8), 32'd0);
        chk("midrun_rst_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n8 = 1'b1;
        @(posedge clk); #1;
        count_done8(12, nd);
        chk("midrun_rst_no_done", 32'(nd), 32'd0);
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, -1, "after_reset");
        idle8("after_reset");

        // random operands against a+b+cin
        for (int i = 0; i < 40; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rc    = 1'($urandom_range(1));
            model = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, model[7:0], model[8], -1, $sformatf("rand%0d", i));
            if ($urandom_range(1) == 1) idle8($sformatf("rand%0d", i));
        end

        // WIDTH=1: whole full-adder truth table
        for (int i = 0; i < 8; i++) begin
            op1(i[2], i[1], i[0], $sformatf("w1_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
